// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} booth_state_t;

  function automatic int unsigned digit_count(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit encoder: maps {b[2i+1], b[2i], b[2i-1]} to neg/one/two selects.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  always_comb begin
    digit = '0;
    case (triplet)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100: begin
        digit.neg = 1'b1;
        digit.two = 1'b1;
      end
      3'b101, 3'b110: begin
        digit.neg = 1'b1;
        digit.one = 1'b1;
      end
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock, start/done handshake.
// Optional early termination when the remaining multiplier bits are all-0/all-1: BOOTH_EARLY_EXIT_EN.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned Digits = digit_count(WIDTH);
  localparam int unsigned IdxW   = $clog2(Digits);
  localparam int unsigned PW     = 2 * WIDTH;

  booth_state_t    state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    acc_q, product_q;
  logic [IdxW-1:0]  idx_q;
  logic             ready_q, busy_q, done_q;

  logic [WIDTH:0]   b_ext;
  logic [2:0]       triplet;
  booth_digit_t     digit;
  logic [PW-1:0]    a_ext, mag, pp, acc_next;
  logic             last_digit;

  // B[-1] = 0 is supplied by the appended LSB.
  assign b_ext   = {b_q, 1'b0};
  assign triplet = b_ext[{idx_q, 1'b0} +: 3];
  assign a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};

  booth_digit_enc u_enc (
    .triplet (triplet),
    .digit   (digit)
  );

  always_comb begin
    mag = '0;
    if (digit.two) begin
      mag = a_ext << 1;
    end else if (digit.one) begin
      mag = a_ext;
    end
    pp       = digit.neg ? (~mag + PW'(1)) : mag;
    acc_next = acc_q + (pp << {idx_q, 1'b0});
  end

`ifdef BOOTH_EARLY_EXIT_EN
  // Remaining digits are all zero once B[WIDTH-1:2i+1] is a pure sign extension.
  always_comb begin
    last_digit = 1'b1;
    for (int j = 0; j < int'(WIDTH); j++) begin
      if (j > 2 * int'(idx_q) && b_q[j] != b_q[WIDTH-1]) last_digit = 1'b0;
    end
  end
`else
  always_comb begin
    last_digit = (idx_q == IdxW'(Digits - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          idx_q <= idx_q + IdxW'(1);
          if (last_digit) begin
            product_q <= acc_next;
            state_q   <= StDone;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
